// File: rtl/seq_tx_pkg.sv
// Shared types and helpers for the seq_tx serial pattern transmitter.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10
    } state_t;

    // Effective pattern length: 0 or anything beyond the register width means "full width".
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/seq_tx_if.sv
// Load/status bundle between a pattern source and seq_tx.
interface seq_tx_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned REP_WIDTH  = 4
);
    logic                  Load;
    logic [DATA_WIDTH-1:0] Data;
    logic [LEN_WIDTH-1:0]  Len;
    logic [REP_WIDTH-1:0]  Reps;
    logic                  Ready;
    logic                  Out1;
    logic                  OutValid;
    logic                  Done;

    modport master (
        output Load, Data, Len, Reps,
        input  Ready, Out1, OutValid, Done
    );

    modport slave (
        input  Load, Data, Len, Reps,
        output Ready, Out1, OutValid, Done
    );
endinterface

// File: rtl/seq_tx_shreg.sv
// Loadable left-shift register; a captured copy allows replaying the pattern.
module seq_tx_shreg #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LEN_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH-1:0]     data,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 reload,
    input  logic                 shift,
    output logic                 out_bit
);
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] copy;
    logic [WIDTH-1:0] aligned;

    // Left-justify the pattern so bit len-1 sits at the MSB and goes out first.
    always_comb begin
        aligned = data << (WIDTH - 32'(len));
    end

    // Load captures both the working register and the replay copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            copy <= '0;
        end else if (load) begin
            sreg <= aligned;
            copy <= aligned;
        end else if (reload) begin
            sreg <= copy;
        end else if (shift) begin
            sreg <= sreg << 1;
        end
    end

    assign out_bit = sreg[WIDTH-1];
endmodule

// File: rtl/seq_tx.sv
// Serial pattern transmitter: sends Len bits of Data MSB-first, Reps+1 times.
module seq_tx
    import seq_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 4,
    parameter int unsigned REP_WIDTH  = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic    CLK,
    input  logic    RST,
    seq_tx_if.slave bus
);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t               state;
    state_t               state_nxt;
    logic [LEN_WIDTH-1:0] eff;
    logic [LEN_WIDTH-1:0] len_m1;
    logic [LEN_WIDTH-1:0] bit_cnt;
    logic [REP_WIDTH-1:0] rep_cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 done_q;
    logic                 do_load;
    logic                 do_shift;
    logic                 do_reload;
    logic                 do_finish;
    logic                 gap_end;
    logic                 sh_bit;

    assign eff = LEN_WIDTH'(eff_len(32'(bus.Len), DATA_WIDTH));

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and datapath strobes; transitions are decided at bit 0.
    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_shift  = 1'b0;
        do_reload = 1'b0;
        do_finish = 1'b0;
        gap_end   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Load) begin
                    do_load   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt != '0) begin
                    do_shift = 1'b1;
                end else if (rep_cnt != '0) begin
                    do_reload = 1'b1;
                    state_nxt = GAP;
                end else begin
                    do_finish = 1'b1;
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    gap_end   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit, repetition and gap counters plus the registered Done pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            len_m1  <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= do_finish;
            if (do_load) begin
                len_m1  <= eff - LEN_WIDTH'(1);
                bit_cnt <= eff - LEN_WIDTH'(1);
                rep_cnt <= bus.Reps;
            end
            if (do_shift) begin
                bit_cnt <= bit_cnt - LEN_WIDTH'(1);
            end
            if (do_reload) begin
                rep_cnt <= rep_cnt - REP_WIDTH'(1);
                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end
            if (state == GAP) begin
                if (gap_end) begin
                    bit_cnt <= len_m1;
                end else begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                end
            end
        end
    end

    seq_tx_shreg #(
        .WIDTH     (DATA_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_shreg (
        .clk     (CLK),
        .rst_n   (RST),
        .load    (do_load),
        .data    (bus.Data),
        .len     (eff),
        .reload  (do_reload),
        .shift   (do_shift),
        .out_bit (sh_bit)
    );

    assign bus.Ready    = (state == IDLE);
    assign bus.OutValid = (state == SHIFT);
    assign bus.Out1     = (state == SHIFT) & sh_bit;
    assign bus.Done     = done_q;
endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: per-cycle model compare plus literal pattern checks.
module tb_seq_tx;
    localparam int DW = 8;
    localparam int LW = 4;
    localparam int RW = 4;
    localparam int GC = 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    seq_tx_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .REP_WIDTH(RW)) bus ();

    seq_tx #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .REP_WIDTH  (RW),
        .GAP_CYCLES (GC)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic ready;
        logic out1;
        logic valid;
        logic done;
    } obs_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } lit_t;

    obs_t        exp_q[$];
    lit_t        lit_q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] cap   = '0;
    int          capn  = 0;
    int          busy  = 0;
    int          dones = 0;

    function automatic int eff_len(int len);
        return ((len == 0) || (len > DW)) ? DW : len;
    endfunction

    // Expected cycle-by-cycle trace of one accepted transmission, from the timing rules.
    function automatic void push_pattern(logic [7:0] d, logic [3:0] len, logic [3:0] reps);
        int L;
        L = eff_len(int'(len));
        for (int r = 0; r <= int'(reps); r++) begin
            for (int i = L - 1; i >= 0; i--) exp_q.push_back({1'b0, d[i], 1'b1, 1'b0});
            if (r < int'(reps))
                for (int g = 0; g < GC; g++) exp_q.push_back(4'b0000);
        end
        exp_q.push_back(4'b1001);
    endfunction

    function automatic logic [63:0] low(logic [63:0] v, int n);
        logic [63:0] m;
        m = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
        return v & m;
    endfunction

    // Single compare process: model step, per-cycle check, capture, literal checks.
    always @(negedge CLK) begin
        obs_t act;
        obs_t exp;
        lit_t l;
        act = {bus.Ready, bus.Out1, bus.OutValid, bus.Done};
        if (!RST) begin
            exp_q.delete();
            exp = 4'b1000;
        end else if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
        end else begin
            exp = 4'b1000;
        end
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL cycle@%0t Ready/Out1/OutValid/Done got %b expected %b", $time, act, exp);
        end
        if (RST) begin
            if (act.valid === 1'b1) begin
                cap = {cap[62:0], act.out1};
                capn++;
            end
            if (act.ready === 1'b0) busy++;
            if (act.done === 1'b1) dones++;
            if (exp.ready && (bus.Load === 1'b1)) push_pattern(bus.Data, bus.Len, bus.Reps);
        end
        while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            vectors++;
            if (l.act !== l.exp) begin
                miscompares++;
                $display("FAIL %s got %0h expected %0h", l.name, l.act, l.exp);
            end
        end
    end

    task automatic lit(string n, logic [63:0] a, logic [63:0] e);
        lit_q.push_back('{n, a, e});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(logic [7:0] d, logic [3:0] len, logic [3:0] reps);
        bus.Load = 1'b1;
        bus.Data = d;
        bus.Len  = len;
        bus.Reps = reps;
        tick();
        bus.Load = 1'b0;
    endtask

    task automatic wait_dones(int target, int budget);
        int n;
        n = 0;
        while ((dones < target) && (n < budget)) begin
            tick();
            n++;
        end
        if (dones < target) lit("done_timeout", 64'(dones), 64'(target));
        tick();
    endtask

    int c0, b0, d0;

    task automatic snap();
        c0 = capn;
        b0 = busy;
        d0 = dones;
    endtask

    initial begin
        bus.Load = 1'b0;
        bus.Data = '0;
        bus.Len  = '0;
        bus.Reps = '0;
        #1 RST = 1'b0;
        repeat (3) tick();
        lit("rst_ready", 64'(bus.Ready), 64'd1);
        lit("rst_out1", 64'(bus.Out1), 64'd0);
        lit("rst_valid", 64'(bus.OutValid), 64'd0);
        lit("rst_done", 64'(bus.Done), 64'd0);
        RST = 1'b1;
        tick();

        // Basic 3-bit pattern 1,0,1.
        snap();
        send(8'h05, 4'd3, 4'd0);
        wait_dones(d0 + 1, 50);
        lit("basic_bits", low(cap, capn - c0), 64'b101);
        lit("basic_count", 64'(capn - c0), 64'd3);
        lit("basic_busy", 64'(busy - b0), 64'd3);

        // Three repeats of A5 with a one-cycle gap; a mid-send Load pulse must be ignored.
        snap();
        send(8'hA5, 4'd8, 4'd2);
        repeat (4) tick();
        bus.Load = 1'b1;
        bus.Data = 8'h00;
        bus.Len  = 4'd2;
        tick();
        bus.Load = 1'b0;
        wait_dones(d0 + 1, 100);
        lit("rep_bits", low(cap, 24), 64'hA5A5A5);
        lit("rep_count", 64'(capn - c0), 64'd24);
        lit("rep_busy", 64'(busy - b0), 64'd26);
        lit("rep_dones", 64'(dones - d0), 64'd1);

        // Length clamping: 0 and 15 both mean the full 8 bits.
        snap();
        send(8'hFF, 4'd0, 4'd0);
        wait_dones(d0 + 1, 50);
        lit("len0_count", 64'(capn - c0), 64'd8);
        lit("len0_bits", low(cap, 8), 64'hFF);
        snap();
        send(8'hFF, 4'd15, 4'd0);
        wait_dones(d0 + 1, 50);
        lit("len15_count", 64'(capn - c0), 64'd8);
        lit("len15_busy", 64'(busy - b0), 64'd8);

        // Back-to-back: Load held across Done; new Data/Len during busy only apply at Done.
        snap();
        bus.Load = 1'b1;
        bus.Data = 8'h0B;
        bus.Len  = 4'd4;
        bus.Reps = 4'd0;
        tick();
        bus.Data = 8'h02;
        bus.Len  = 4'd2;
        begin
            int n;
            n = 0;
            while ((dones < d0 + 1) && (n < 50)) begin
                tick();
                n++;
            end
        end
        tick();
        bus.Load = 1'b0;
        wait_dones(d0 + 2, 50);
        lit("b2b_bits", low(cap, capn - c0), 64'b101110);
        lit("b2b_count", 64'(capn - c0), 64'd6);
        lit("b2b_busy", 64'(busy - b0), 64'd6);
        lit("b2b_dones", 64'(dones - d0), 64'd2);

        // Reset during the 4th bit of an 8-bit send, then a fresh two-repeat transmission.
        snap();
        send(8'hC3, 4'd8, 4'd0);
        repeat (3) tick();
        #1 RST = 1'b0;
        #1;
        lit("arst_out1", 64'(bus.Out1), 64'd0);
        lit("arst_valid", 64'(bus.OutValid), 64'd0);
        lit("arst_ready", 64'(bus.Ready), 64'd1);
        lit("arst_done", 64'(bus.Done), 64'd0);
        repeat (3) tick();
        RST = 1'b1;
        lit("arst_partial", low(cap, capn - c0), 64'b110);
        tick();
        lit("arst_no_done", 64'(dones - d0), 64'd0);
        snap();
        send(8'h96, 4'd8, 4'd1);
        wait_dones(d0 + 1, 100);
        lit("post_bits", low(cap, 16), 64'h9696);
        lit("post_count", 64'(capn - c0), 64'd16);
        lit("post_busy", 64'(busy - b0), 64'd17);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/seq_tx.md
# seq_tx

Serial pattern transmitter: accepts a parallel bit pattern with a length and repeat count, then drives it one bit per clock onto a single serial line. It is the stimulus/transmit side of the single-bit sequence-detector FSMs. Its `Out1` connects directly to a detector's `In1` on the same `CLK`/`RST` domain.

## Interface
- `DATA_WIDTH`, 8: maximum pattern length in bits.
- `LEN_WIDTH`, 4: width of `Len`; must hold the value `DATA_WIDTH`.
- `REP_WIDTH`, 4: width of `Reps`.
- `GAP_CYCLES`, 1: idle cycles between repetitions; must be ≥1.
- `CLK` in 1: single clock; all state changes on its rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `Load` in 1: request to start a transmission.
- `Data` in DATA_WIDTH: pattern to send; bit `Len-1` is sent first, bit 0 last.
- `Len` in LEN_WIDTH: number of bits to send. A value of 0 or greater than `DATA_WIDTH` sends `DATA_WIDTH` bits.
- `Reps` in REP_WIDTH: the pattern is sent `Reps+1` times.
- `Ready` out 1: idle; a `Load` is accepted this cycle.
- `Out1` out 1: serial data, registered.
- `OutValid` out 1: `Out1` carries a pattern bit this cycle.
- `Done` out 1: one-cycle pulse after the final bit of the final repetition.

## Operation
- States: `IDLE`, `SHIFT`, `GAP`.
- Reset (`RST` low) asynchronously forces:
  - state `IDLE`;
  - `Ready`=1, `Out1`=0, `OutValid`=0, `Done`=0;
  - all counters and the shift register cleared.
- `IDLE`: `Ready`=1, `Out1`=0, `OutValid`=0.
  - `Load`=1 at a rising edge captures `Data`, the effective length L, and `Reps`, then enters `SHIFT`.
  - `Load`=0 stays in `IDLE`.
- `SHIFT`: `Ready`=0, `OutValid`=1, `Out1` = current pattern bit.
  - A bit counter runs from L-1 down to 0.
  - At bit 0 with repetitions remaining: go to `GAP` and decrement the repetition counter.
  - At bit 0 with none remaining: go to `IDLE` and pulse `Done`.
- `GAP`: `Ready`=0, `OutValid`=0, `Out1`=0.
  - Lasts exactly `GAP_CYCLES` cycles.
  - The shift register reloads from the captured copy of `Data`; `Data` is not resampled.
  - Then returns to `SHIFT` at bit L-1.
- While `Ready`=0, `Load` is ignored; `Data`/`Len`/`Reps` changes have no effect.
- `Done` and `Ready` rise in the same cycle. A `Load` sampled in that cycle is accepted, giving back-to-back transmissions with zero idle cycles.
- Counter arithmetic is unsigned. The repetition counter never wraps below 0; the transition is decided at 0.

## Timing
- Edge k accepts a `Load`. Bit `Len-1` is on `Out1` with `OutValid`=1 in cycle k+1.
- Last bit is in cycle k+L.
- Total busy cycles: (Reps+1)·L + Reps·GAP_CYCLES.
- `Done`=1 and `Ready`=1 in the cycle after the final bit.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-transmission: outputs take reset values immediately, with no `Done` pulse. After `RST` deasserts, the first accepted `Load` starts a fresh pattern.

## Structure
- Package `seq_tx_pkg` holds:
  - the state encoding localparams `IDLE`=2'b00, `SHIFT`=2'b01, `GAP`=2'b10 (2'b11 recovers to `IDLE`);
  - a function computing the effective length from `Len` and `DATA_WIDTH`.
- One sub-module: `seq_tx_shreg`, a loadable left-shift register with a captured-copy reload port, supplying `Out1`.
- Top level holds the FSM, bit counter, repetition counter, and gap counter.

## Test plan
- **Basic pattern:** Reset, then `Load`=1, `Data`=8'h05, `Len`=3, `Reps`=0. Required: `Out1`=1,0,1 with `OutValid`=1 in cycles 1–3; `Done`=1 in cycle 4. A chained detector's `Out1` follows state C.
- **Repeats with gap:** `Data`=8'hA5, `Len`=8, `Reps`=2, `GAP_CYCLES`=1. Required: 10100101, one low gap cycle, repeat; 26 busy cycles; a single `Done`.
- **Length clamping:** `Len`=0 and, separately, `Len`=15 with `Data`=8'hFF. Required: exactly 8 ones, then `Done`.
- **Back-to-back:** Hold `Load`=1 across `Done` with new `Data`=8'h02, `Len`=2. Required: the second pattern (1,0) starts in the cycle after `Done` with no idle cycle. `Load` pulses issued mid-transmission are ignored.
- **Reset mid-transmission:** Assert `RST` low asynchronously during bit 4 of an 8-bit send. Required: `Out1`=0, `OutValid`=0, `Ready`=1 immediately, and no `Done`. A subsequent `Load` transmits correctly.
